// File: rtl/sram_arbiter_if.sv
// sram_arbiter_if: requester handshakes and SRAM pad bundle for sram_arbiter.
interface sram_arbiter_if;
   logic        ppu_req;
   logic [18:0] ppu_addr;
   logic        ppu_ack;
   logic [7:0]  ppu_q;
   logic        cpu_req;
   logic        cpu_we;
   logic [18:0] cpu_addr;
   logic [7:0]  cpu_d;
   logic        cpu_ack;
   logic [7:0]  cpu_q;
   logic        ld_req;
   logic [17:0] ld_addr;
   logic [15:0] ld_d;
   logic        ld_ack;
   logic [17:0] ADR;
   logic [15:0] DAT_o;
   logic [15:0] DAT_i;
   logic        DAT_oe;
   logic        RAMOE;
   logic        RAMWE;
   logic        RAMCS;
   logic        busy;
   modport slave (
      input  ppu_req, ppu_addr, cpu_req, cpu_we, cpu_addr, cpu_d, ld_req, ld_addr, ld_d, DAT_i,
      output ppu_ack, ppu_q, cpu_ack, cpu_q, ld_ack, ADR, DAT_o, DAT_oe, RAMOE, RAMWE, RAMCS, busy
   );
   modport master (
      output ppu_req, ppu_addr, cpu_req, cpu_we, cpu_addr, cpu_d, ld_req, ld_addr, ld_d, DAT_i,
      input  ppu_ack, ppu_q, cpu_ack, cpu_q, ld_ack, ADR, DAT_o, DAT_oe, RAMOE, RAMWE, RAMCS, busy
   );
endinterface

// File: rtl/sram_arbiter.sv
// sram_arbiter: shares one async 16-bit SRAM between PPU reads, CPU byte read/write and loader word writes.
// Define SRAM_ARB_RR_EN to put CPU and loader in round-robin below the PPU.
module sram_arbiter #(
   parameter int RD_WAIT   = 2,
   parameter int WE_CYCLES = 2
) (
   input logic clock,
   input logic reset,
   sram_arbiter_if.slave bus
);
   typedef enum logic [2:0] {IDLE, RD, WR_SETUP, WR_PULSE, WR_HOLD} state_t;
   typedef enum logic [1:0] {OWN_PPU, OWN_CPU_RD, OWN_CPU_WR, OWN_LD} own_t;
   state_t state, nxt;
   own_t own;
   logic [2:0] cnt;
   logic lane, ack_d, quiet, last, gnt_ppu, gnt_cpu, gnt_ld;
`ifdef SRAM_ARB_RR_EN
   logic rr;
`endif
   // No grant while an ack is up or was up last cycle, so a requester still holding req is never served twice
   assign quiet = !(bus.ppu_ack || bus.cpu_ack || bus.ld_ack || ack_d);
   assign gnt_ppu = quiet && bus.ppu_req;
`ifdef SRAM_ARB_RR_EN
   assign gnt_cpu = quiet && !bus.ppu_req && bus.cpu_req && !(bus.ld_req && rr);
`else
   assign gnt_cpu = quiet && !bus.ppu_req && bus.cpu_req;
`endif
   assign gnt_ld = quiet && !bus.ppu_req && bus.ld_req && !gnt_cpu;
   assign last = (state == RD) ? cnt == 3'(RD_WAIT - 1) : cnt == 3'(WE_CYCLES - 1);
   always_ff @(posedge clock or posedge reset)
      if (reset) state <= IDLE;
      else state <= nxt;
   always_comb begin
      nxt = state;
      case (state)
         IDLE:     nxt = (gnt_ppu || gnt_cpu) ? RD : gnt_ld ? WR_SETUP : IDLE;
         RD:       nxt = !last ? RD : (own == OWN_CPU_WR) ? WR_SETUP : IDLE;
         WR_SETUP: nxt = WR_PULSE;
         WR_PULSE: nxt = last ? WR_HOLD : WR_PULSE;
         default:  nxt = IDLE;
      endcase
   end
   // Strobes are registered from the next state so every pad change lines up with the state change
   always_ff @(posedge clock or posedge reset)
      if (reset) begin
         own         <= OWN_PPU;
         cnt         <= '0;
         lane        <= 1'b0;
         ack_d       <= 1'b0;
         bus.ppu_ack <= 1'b0;
         bus.cpu_ack <= 1'b0;
         bus.ld_ack  <= 1'b0;
         bus.ppu_q   <= '0;
         bus.cpu_q   <= '0;
         bus.ADR     <= '0;
         bus.DAT_o   <= '0;
         bus.DAT_oe  <= 1'b0;
         bus.RAMOE   <= 1'b1;
         bus.RAMWE   <= 1'b1;
         bus.RAMCS   <= 1'b1;
         bus.busy    <= 1'b0;
`ifdef SRAM_ARB_RR_EN
         rr          <= 1'b0;
`endif
      end else begin
         ack_d       <= bus.ppu_ack || bus.cpu_ack || bus.ld_ack;
         bus.ppu_ack <= 1'b0;
         bus.cpu_ack <= 1'b0;
         bus.ld_ack  <= 1'b0;
         cnt         <= (state == nxt) ? cnt + 3'd1 : 3'd0;
         bus.RAMCS   <= nxt == IDLE;
         bus.RAMOE   <= nxt != RD;
         bus.RAMWE   <= nxt != WR_PULSE;
         bus.DAT_oe  <= nxt == WR_SETUP || nxt == WR_PULSE || nxt == WR_HOLD;
         bus.busy    <= nxt != IDLE;
         if (state == IDLE && nxt != IDLE) begin
            own     <= gnt_ppu ? OWN_PPU : gnt_cpu ? (bus.cpu_we ? OWN_CPU_WR : OWN_CPU_RD) : OWN_LD;
            bus.ADR <= gnt_ppu ? bus.ppu_addr[18:1] : gnt_cpu ? bus.cpu_addr[18:1] : bus.ld_addr;
            lane    <= gnt_ppu ? bus.ppu_addr[0] : bus.cpu_addr[0];
            if (gnt_ld) bus.DAT_o <= bus.ld_d;
`ifdef SRAM_ARB_RR_EN
            if (gnt_cpu || gnt_ld) rr <= gnt_cpu;
`endif
         end
         if (state == RD && last) begin
            if (own == OWN_PPU) begin
               bus.ppu_ack <= 1'b1;
               bus.ppu_q   <= lane ? bus.DAT_i[15:8] : bus.DAT_i[7:0];
            end
            if (own == OWN_CPU_RD) begin
               bus.cpu_ack <= 1'b1;
               bus.cpu_q   <= lane ? bus.DAT_i[15:8] : bus.DAT_i[7:0];
            end
            if (own == OWN_CPU_WR)
               bus.DAT_o <= lane ? {bus.cpu_d, bus.DAT_i[7:0]} : {bus.DAT_i[15:8], bus.cpu_d};
         end
         if (state == WR_PULSE && last) begin
            bus.ld_ack  <= own == OWN_LD;
            bus.cpu_ack <= own == OWN_CPU_WR;
         end
      end
endmodule

// File: tb/tb_sram_arbiter.sv
// tb_sram_arbiter: table-driven vectors plus multi-cycle sequences for sram_arbiter.
module tb_sram_arbiter;
   logic clock = 1'b0;
   logic reset = 1'b1;
   always #5 clock = ~clock;
   sram_arbiter_if bus();
   sram_arbiter #(.RD_WAIT(2), .WE_CYCLES(2)) dut (.clock(clock), .reset(reset), .bus(bus));

   int errors = 0;
   int checks = 0;
   logic [15:0] mem [0:15];
   logic        pre_en = 1'b0;
   logic [3:0]  pre_idx = '0;
   logic [15:0] pre_val = '0;
   int clash = 0, oe_lo = 0, we_lo = 0, doe_hi = 0, n_ppu = 0, n_cpu = 0, n_ld = 0;
   int order [$];

   always @(posedge clock)
      if (pre_en) mem[pre_idx] <= pre_val;
      else if (!bus.RAMCS && !bus.RAMWE && bus.DAT_oe) mem[bus.ADR[3:0]] <= bus.DAT_o;
   assign bus.DAT_i = (!bus.RAMCS && !bus.RAMOE) ? mem[bus.ADR[3:0]] : 16'h0000;

   always @(negedge clock) begin
      if (!bus.RAMOE && bus.DAT_oe) clash++;
      if (!bus.RAMOE) oe_lo++;
      if (!bus.RAMWE) we_lo++;
      if (bus.DAT_oe) doe_hi++;
      if (bus.ppu_ack) begin n_ppu++; order.push_back(1); end
      if (bus.cpu_ack) begin n_cpu++; order.push_back(2); end
      if (bus.ld_ack) begin n_ld++; order.push_back(3); end
   end

   typedef struct {
      int          kind;
      logic [18:0] addr;
      logic [15:0] d;
      logic [15:0] init;
      logic [15:0] exp;
      int          lat;
      int          oe;
      int          we;
      int          doe;
      logic [17:0] adr;
   } vec_t;
   vec_t vecs [8];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic int ord(input int i);
      return (i < order.size()) ? order[i] : -1;
   endfunction

   task automatic preload(input logic [3:0] idx, input logic [15:0] val);
      @(posedge clock);
      #1;
      pre_idx = idx;
      pre_val = val;
      pre_en  = 1'b1;
      @(posedge clock);
      #1;
      pre_en = 1'b0;
   endtask

   task automatic run_vec(input vec_t v, input int i);
      int lat, oe0, we0, doe0;
      bit done;
      logic [15:0] res;
      preload(v.adr[3:0], v.init);
      oe0 = oe_lo; we0 = we_lo; doe0 = doe_hi;
      case (v.kind)
         0: begin bus.ppu_addr = v.addr; bus.ppu_req = 1'b1; end
         1: begin bus.cpu_addr = v.addr; bus.cpu_we = 1'b0; bus.cpu_req = 1'b1; end
         2: begin bus.cpu_addr = v.addr; bus.cpu_we = 1'b1; bus.cpu_d = v.d[7:0]; bus.cpu_req = 1'b1; end
         default: begin bus.ld_addr = v.addr[17:0]; bus.ld_d = v.d; bus.ld_req = 1'b1; end
      endcase
      lat = 0;
      done = 1'b0;
      while (!done && lat < 30) begin
         @(negedge clock);
         lat++;
         done = (v.kind == 0) ? bus.ppu_ack : (v.kind == 3) ? bus.ld_ack : bus.cpu_ack;
      end
      bus.ppu_req = 1'b0;
      bus.cpu_req = 1'b0;
      bus.ld_req  = 1'b0;
      repeat (4) @(posedge clock);
      @(negedge clock);
      res = (v.kind == 0) ? {8'h00, bus.ppu_q} : (v.kind == 1) ? {8'h00, bus.cpu_q} : mem[v.adr[3:0]];
      check($sformatf("v%0d_latency", i), lat, v.lat);
      check($sformatf("v%0d_data", i), res, v.exp);
      check($sformatf("v%0d_oe_low_cycles", i), oe_lo - oe0, v.oe);
      check($sformatf("v%0d_we_low_cycles", i), we_lo - we0, v.we);
      check($sformatf("v%0d_dat_oe_cycles", i), doe_hi - doe0, v.doe);
      check($sformatf("v%0d_adr", i), bus.ADR, v.adr);
   endtask

   initial begin
      int s, cyc, cd, ld0, exp_ld;
      bit cre, lre;
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int s, cyc, cd, ld0, exp_ld;
      bit cre, lre;
      vecs[0] = '{0, 19'h00003, 16'h0000, 16'hA55A, 16'h00A5, 4, 2, 0, 0, 18'h00001};
      vecs[1] = '{0, 19'h00004, 16'h0000, 16'h1234, 16'h0034, 4, 2, 0, 0, 18'h00002};
      vecs[2] = '{1, 19'h00007, 16'h0000, 16'hC3D2, 16'h00C3, 4, 2, 0, 0, 18'h00003};
      vecs[3] = '{1, 19'h0000E, 16'h0000, 16'h9F01, 16'h0001, 4, 2, 0, 0, 18'h00007};
      vecs[4] = '{3, 19'h3FFFF, 16'h1234, 16'h0000, 16'h1234, 5, 0, 2, 4, 18'h3FFFF};
      vecs[5] = '{2, 19'h00000, 16'h007E, 16'hBEEF, 16'hBE7E, 7, 2, 2, 4, 18'h00000};
      vecs[6] = '{2, 19'h0000B, 16'h005A, 16'h1122, 16'h5A22, 7, 2, 2, 4, 18'h00005};
      vecs[7] = '{3, 19'h00006, 16'hCAFE, 16'h0000, 16'hCAFE, 5, 0, 2, 4, 18'h00006};
      bus.ppu_req = 1'b0; bus.ppu_addr = '0;
      bus.cpu_req = 1'b0; bus.cpu_we = 1'b0; bus.cpu_addr = '0; bus.cpu_d = '0;
      bus.ld_req = 1'b0; bus.ld_addr = '0; bus.ld_d = '0;
      repeat (3) @(posedge clock);
      @(negedge clock);
      check("rst_strobes", {bus.RAMOE, bus.RAMWE, bus.RAMCS, bus.DAT_oe}, 4'b1110);
      check("rst_adr_dato", {bus.ADR, bus.DAT_o}, 34'h0);
      check("rst_acks_busy", {bus.ppu_ack, bus.cpu_ack, bus.ld_ack, bus.busy}, 4'b0000);
      check("rst_q", {bus.ppu_q, bus.cpu_q}, 16'h0000);
      reset = 1'b0;
      for (int i = 0; i < 8; i++) run_vec(vecs[i], i);

      // all three requesters raised together
      s = order.size();
      @(posedge clock);
      #1;
      bus.ppu_addr = 19'h00008; bus.cpu_addr = 19'h0000A; bus.cpu_we = 1'b0;
      bus.ld_addr = 18'h00009; bus.ld_d = 16'h4444;
      bus.ppu_req = 1'b1; bus.cpu_req = 1'b1; bus.ld_req = 1'b1;
      cyc = 0;
      while ((bus.ppu_req || bus.cpu_req || bus.ld_req) && cyc < 80) begin
         @(negedge clock);
         cyc++;
         if (bus.ppu_ack) bus.ppu_req = 1'b0;
         if (bus.cpu_ack) bus.cpu_req = 1'b0;
         if (bus.ld_ack) bus.ld_req = 1'b0;
      end
      check("sim_timeout", cyc >= 80, 0);
      repeat (6) @(negedge clock);
      check("sim_ack_count", order.size() - s, 3);
      check("sim_first", ord(s), 1);
      check("sim_second", ord(s + 1), 2);
      check("sim_third", ord(s + 2), 3);

      // loader held while CPU issues back-to-back reads
      ld0 = n_ld;
      @(posedge clock);
      #1;
      bus.ld_addr = 18'h0000C; bus.ld_d = 16'hBBBB;
      bus.cpu_addr = 19'h00010; bus.cpu_we = 1'b0;
      bus.ld_req = 1'b1; bus.cpu_req = 1'b1;
      cd = 0;
      cyc = 0;
      while (cd < 4 && cyc < 200) begin
         @(negedge clock);
         cyc++;
         cre = 1'b0;
         lre = 1'b0;
         if (bus.cpu_ack) begin cd++; bus.cpu_req = 1'b0; cre = (cd < 4); end
         if (bus.ld_ack) begin bus.ld_req = 1'b0; lre = 1'b1; end
         if (cre || lre) begin
            @(posedge clock);
            #1;
            if (cre) begin bus.cpu_addr = bus.cpu_addr + 19'd2; bus.cpu_req = 1'b1; end
            if (lre) bus.ld_req = 1'b1;
         end
      end
      bus.ld_req = 1'b0;
      check("b2b_timeout", cyc >= 200, 0);
      repeat (12) @(negedge clock);
`ifdef SRAM_ARB_RR_EN
      exp_ld = 3;
`else
      exp_ld = 0;
`endif
      check("b2b_loader_grants", n_ld - ld0, exp_ld);
      check("no_oe_dat_oe_overlap", clash, 0);

      // asynchronous reset in the middle of a write pulse
      preload(4'hD, 16'h0101);
      ld0 = n_ld;
      bus.ld_addr = 18'h0000D; bus.ld_d = 16'h7777; bus.ld_req = 1'b1;
      repeat (3) @(negedge clock);
      check("rstw_in_pulse", {bus.RAMWE, bus.DAT_oe}, 2'b01);
      #1 reset = 1'b1;
      #1;
      check("rstw_strobes_async", {bus.RAMOE, bus.RAMWE, bus.RAMCS, bus.DAT_oe}, 4'b1110);
      bus.ld_req = 1'b0;
      @(posedge clock);
      @(negedge clock);
      reset = 1'b0;
      repeat (3) @(negedge clock);
      check("rstw_idle", {bus.busy, bus.RAMCS}, 2'b01);
      check("rstw_no_ack", n_ld - ld0, 0);
      check("rstw_mem_kept", mem[13], 16'h0101);
      run_vec(vecs[0], 8);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
